sp2_spi_capture: RTL and testbench
==================================

// Module: sp2_spi_capture
// PURPOSE
//   Receiving end of the SP2 display SPI link: decodes the ST7789-style command/data stream
//   that sp2_spi_driver emits and rebuilds pixels as framebuffer writes (addr, RGB565).
//   Used for on-chip loopback checking of the display path and as a synthesizable panel
//   model in system benches. It sits on the spi_* nets in parallel with (or instead of) the panel.
// PARAMETERS
//   H_RES     320  panel columns; pixel address = row*H_RES + col
//   V_RES     172  panel rows
//   X_OFS     0    column offset subtracted from CASET values
//   Y_OFS     34   row offset subtracted from RASET values
// PORTS
//   clk             in   1   capture clock; must be >= 4x SCK frequency
//   rst_n_in        in   1   asynchronous active-low reset
//   spi_cs_n        in   1   chip select, active low (asynchronous to clk)
//   spi_sck         in   1   SPI clock, mode 0 (sample on rising edge)
//   spi_mosi        in   1   data, MSB first
//   spi_dc          in   1   0 = command byte, 1 = data byte
//   pix_wr_en       out  1   one-cycle strobe per reconstructed pixel
//   pix_wr_addr     out  16  row*H_RES + col
//   pix_wr_data     out  16  RGB565 (high byte received first)
//   byte_valid      out  1   one-cycle strobe per completed byte
//   byte_data       out  8   completed byte
//   byte_is_cmd     out  1   DC level latched at the byte's 8th SCK rise
//   frame_done      out  1   one-cycle strobe when the last pixel of the window is written
//   err_partial     out  1   sticky: CS deasserted with 1..7 bits pending
//   err_oob         out  1   sticky: pixel fell outside H_RES x V_RES and was dropped
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; window = (0,0)..(H_RES-1,V_RES-1); cursor = (0,0).
//   Input sync: cs_n, sck, mosi, dc go through 2-FF synchronisers; SCK rise is detected on the
//     synchronised signal. mosi/dc are sampled in the same cycle the rise is detected.
//   Bit assembly: 3-bit counter, shift left; it clears while CS is high. On the 8th bit,
//     byte_valid pulses 1 cycle later with byte_data/byte_is_cmd. Latency from the 8th SCK rise
//     to byte_valid is 3-4 clk.
//   CS rise with count != 0: the partial byte is discarded and err_partial is set. The FSM
//     state and the cursor are kept, so a RAMWR burst can span CS toggles.
//   FSM (advances on byte_valid only):
//     IDLE/any + cmd byte: 0x2A->CASET, 0x2B->RASET, 0x2C->RAMWR, other->SKIP. A cmd byte
//       always aborts the current state and discards any half pixel.
//     CASET: 4 data bytes XS[15:8],XS[7:0],XE[15:8],XE[7:0] -> xs=XS-X_OFS, xe=XE-X_OFS;
//       then IDLE. RASET works the same way with Y_OFS. Extra data bytes are ignored (SKIP).
//     RAMWR: entry sets cursor=(xs,ys) and clears the half-pixel flag. Even data byte -> hi
//       byte. Odd data byte -> pixel {hi,byte}. pix_wr_en is asserted the cycle after the odd
//       byte's byte_valid.
//       Cursor advance: col++ ; if col==xe then col=xs, row++ ; if row==ye also then row=ys
//       and frame_done pulses together with that last pix_wr_en.
//     SKIP: data bytes are consumed with no effect.
//   Arithmetic: offset subtraction is 16-bit wrap. Address = row*H_RES+col, computed with a
//     16-bit multiply or shift-add and registered. If col>=H_RES or row>=V_RES, pix_wr_en
//     stays low and err_oob is set. The cursor still advances.
//   Window with xs>xe or ys>ye: col/row only wrap on equality, so the pixel is out-of-bounds
//     until the 16-bit wrap. No special handling.
//   Reset mid-burst: asynchronous return to reset values. Sticky flags clear only on reset.
// TESTING
//   1. Byte path: CS low, DC=0, send 0xA5 at SCK=clk/4 -> byte_valid once, byte_data=0xA5,
//      byte_is_cmd=1.
//   2. Window+pixels: CASET 0,0,0,1 ; RASET 0,34,0,35 ; RAMWR + 8 bytes F8 00 07 E0 00 1F FF FF
//      -> writes (0,F800) (1,07E0) (320,001F) (321,FFFF); frame_done with the 4th write.
//   3. Wrap: repeat the same RAMWR with 10 data bytes -> 5th pixel goes to addr 0 again.
//      The second frame_done comes at the 4th write, not the 5th.
//   4. Partial byte: 5 bits then CS high -> err_partial=1, no byte_valid. Next full byte
//      decodes correctly.
//   5. Abort/OOB: RAMWR, 1 data byte, cmd 0x00 -> no pixel. CASET XS=XE=400 then RAMWR 2 bytes
//      -> err_oob=1, pix_wr_en never asserted.
//   6. Full frame: loop sp2_spi_driver output into this block -> 55040 writes match the source
//      framebuffer, and exactly one frame_done per driver frame_done.

Source files
------------

// File: rtl/sp2_spi_capture.sv
// Receiving end of the SP2 display SPI link: decodes the ST7789-style command/data
// stream and rebuilds pixels as framebuffer writes (row*H_RES+col, RGB565).
module sp2_spi_capture #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 172,
  parameter int unsigned X_OFS = 0,
  parameter int unsigned Y_OFS = 34
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  output logic        pix_wr_en,
  output logic [15:0] pix_wr_addr,
  output logic [15:0] pix_wr_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_cmd,
  output logic        frame_done,
  output logic        err_partial,
  output logic        err_oob
);

  localparam logic [15:0] H_RES16 = 16'(H_RES);
  localparam logic [15:0] V_RES16 = 16'(V_RES);
  localparam logic [15:0] X_OFS16 = 16'(X_OFS);
  localparam logic [15:0] Y_OFS16 = 16'(Y_OFS);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_SKIP
  } state_t;

  state_t state, state_nxt;

  logic [1:0] cs_sync, sck_sync, mosi_sync, dc_sync;
  logic       sck_q;
  logic       cs_s, mosi_s, dc_s, sck_rise;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  logic [1:0]  arg_idx;
  logic [7:0]  arg_hi;
  logic [15:0] arg_start;
  logic [15:0] xs, xe, ys, ye, col, row;
  logic [7:0]  pix_hi;
  logic        half;
  logic [15:0] addr_c;
  logic        in_bounds_c;
  logic        ld_arg, commit_x, commit_y, pix_byte, enter_ramwr;

  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign dc_s     = dc_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_q;

  // Two-stage synchronisers for all SPI pins; CS idles high
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      dc_sync   <= 2'b00;
      sck_q     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      dc_sync   <= {dc_sync[0], spi_dc};
      sck_q     <= sck_sync[1];
    end
  end

  // Bit assembly; CS high drops any partial byte
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'd0;
      byte_is_cmd <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        if (bit_cnt != 3'd0) err_partial <= 1'b1;
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        shift   <= {shift[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid  <= 1'b1;
          byte_data   <= {shift[6:0], mosi_s};
          byte_is_cmd <= ~dc_s;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Command decoder: a command byte always overrides the current state
  always_comb begin
    state_nxt   = state;
    ld_arg      = 1'b0;
    commit_x    = 1'b0;
    commit_y    = 1'b0;
    pix_byte    = 1'b0;
    enter_ramwr = 1'b0;
    if (byte_valid) begin
      if (byte_is_cmd) begin
        case (byte_data)
          CMD_CASET: state_nxt = ST_CASET;
          CMD_RASET: state_nxt = ST_RASET;
          CMD_RAMWR: begin
            state_nxt   = ST_RAMWR;
            enter_ramwr = 1'b1;
          end
          default:   state_nxt = ST_SKIP;
        endcase
      end else begin
        case (state)
          ST_CASET: begin
            ld_arg = 1'b1;
            if (arg_idx == 2'd3) begin
              commit_x  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_RASET: begin
            ld_arg = 1'b1;
            if (arg_idx == 2'd3) begin
              commit_y  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_RAMWR: pix_byte = 1'b1;
          default:  ;
        endcase
      end
    end
  end

  assign addr_c      = row * H_RES16 + col;
  assign in_bounds_c = (col < H_RES16) && (row < V_RES16);

  // Window registers, cursor and pixel write port
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      arg_idx     <= 2'd0;
      arg_hi      <= 8'd0;
      arg_start   <= 16'd0;
      xs          <= 16'd0;
      xe          <= H_RES16 - 16'd1;
      ys          <= 16'd0;
      ye          <= V_RES16 - 16'd1;
      col         <= 16'd0;
      row         <= 16'd0;
      pix_hi      <= 8'd0;
      half        <= 1'b0;
      pix_wr_en   <= 1'b0;
      pix_wr_addr <= 16'd0;
      pix_wr_data <= 16'd0;
      frame_done  <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      pix_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid && byte_is_cmd) begin
        arg_idx <= 2'd0;
        half    <= 1'b0;
      end
      if (enter_ramwr) begin
        col <= xs;
        row <= ys;
      end
      if (ld_arg) begin
        arg_idx <= arg_idx + 2'd1;
        case (arg_idx)
          2'd0:    arg_hi    <= byte_data;
          2'd1:    arg_start <= {arg_hi, byte_data};
          2'd2:    arg_hi    <= byte_data;
          default: ;
        endcase
      end
      if (commit_x) begin
        xs <= arg_start - X_OFS16;
        xe <= {arg_hi, byte_data} - X_OFS16;
      end
      if (commit_y) begin
        ys <= arg_start - Y_OFS16;
        ye <= {arg_hi, byte_data} - Y_OFS16;
      end
      if (pix_byte) begin
        if (!half) begin
          pix_hi <= byte_data;
          half   <= 1'b1;
        end else begin
          half      <= 1'b0;
          pix_wr_en <= in_bounds_c;
          if (in_bounds_c) begin
            pix_wr_addr <= addr_c;
            pix_wr_data <= {pix_hi, byte_data};
          end else begin
            err_oob <= 1'b1;
          end
          // Wrap only on equality; reversed windows run until the 16-bit wrap
          if (col == xe) begin
            col <= xs;
            if (row == ye) begin
              row        <= ys;
              frame_done <= in_bounds_c;
            end else begin
              row <= row + 16'd1;
            end
          end else begin
            col <= col + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sp2_spi_capture.sv
// Directed bench for sp2_spi_capture: expected bytes and pixels are queued as the
// SPI stream is driven and checked as the DUT emits them.
module tb_sp2_spi_capture;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        spi_cs_n, spi_sck, spi_mosi, spi_dc;
  logic        pix_wr_en;
  logic [15:0] pix_wr_addr, pix_wr_data;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_cmd;
  logic        frame_done;
  logic        err_partial, err_oob;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  exp_b[$];   // {is_cmd, data}
  logic [32:0] exp_p[$];   // {frame_done, addr, data}

  always #5 clk = ~clk;

  sp2_spi_capture dut (
    .clk         (clk),
    .rst_n_in    (rst_n_in),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_dc      (spi_dc),
    .pix_wr_en   (pix_wr_en),
    .pix_wr_addr (pix_wr_addr),
    .pix_wr_data (pix_wr_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_is_cmd (byte_is_cmd),
    .frame_done  (frame_done),
    .err_partial (err_partial),
    .err_oob     (err_oob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCK = clk/4, mode 0, one CS frame per byte
  task automatic send_byte(input logic dc, input logic [7:0] b);
    spi_dc   = dc;
    spi_cs_n = 1'b0;
    exp_b.push_back({~dc, b});
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      wait_clk(2);
      spi_sck = 1'b1;
      wait_clk(2);
      spi_sck = 1'b0;
    end
    wait_clk(2);
    spi_cs_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic push_pix(input logic [15:0] a, input logic [15:0] d, input logic fd);
    exp_p.push_back({fd, a, d});
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n_in) begin
      if (byte_valid) begin
        chk("byte_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          logic [8:0] e;
          e = exp_b.pop_front();
          chk("byte_data", 32'(byte_data), 32'(e[7:0]));
          chk("byte_is_cmd", 32'(byte_is_cmd), 32'(e[8]));
        end
      end
      if (pix_wr_en) begin
        chk("pix_expected", 32'(exp_p.size() != 0), 32'd1);
        if (exp_p.size() != 0) begin
          logic [32:0] e;
          e = exp_p.pop_front();
          chk("pix_addr", 32'(pix_wr_addr), 32'(e[31:16]));
          chk("pix_data", 32'(pix_wr_data), 32'(e[15:0]));
          chk("frame_done", 32'(frame_done), 32'(e[32]));
        end
      end
      if (frame_done) chk("frame_done_with_wr", 32'(pix_wr_en), 32'd1);
    end
  end

  initial begin
    rst_n_in = 1'b0;
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_dc   = 1'b0;
    wait_clk(3);
    chk("rst_pix_wr_en", 32'(pix_wr_en), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_pix_addr", 32'(pix_wr_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_partial", 32'(err_partial), 32'd0);
    chk("rst_err_oob", 32'(err_oob), 32'd0);
    rst_n_in = 1'b1;
    wait_clk(3);

    // Single command byte on the byte path
    send_byte(1'b0, 8'hA5);

    // Window (0..1, 34..35 raw) then four pixels
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h23);
    push_pix(16'd0,   16'hF800, 1'b0);
    push_pix(16'd1,   16'h07E0, 1'b0);
    push_pix(16'd320, 16'h001F, 1'b0);
    push_pix(16'd321, 16'hFFFF, 1'b1);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h07); send_byte(1'b1, 8'hE0);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h1F);
    send_byte(1'b1, 8'hFF); send_byte(1'b1, 8'hFF);

    // Five pixels into a 2x2 window: the fifth wraps to address 0
    push_pix(16'd0,   16'h0102, 1'b0);
    push_pix(16'd1,   16'h0304, 1'b0);
    push_pix(16'd320, 16'h0506, 1'b0);
    push_pix(16'd321, 16'h0708, 1'b1);
    push_pix(16'd0,   16'h090A, 1'b0);
    send_byte(1'b0, 8'h2C);
    for (int i = 1; i <= 10; i++) send_byte(1'b1, 8'(i));
    wait_clk(4);
    chk("no_partial_yet", 32'(err_partial), 32'd0);

    // Five bits then CS high: partial byte dropped
    spi_dc   = 1'b1;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'(i & 1);
      wait_clk(2);
      spi_sck = 1'b1;
      wait_clk(2);
      spi_sck = 1'b0;
    end
    wait_clk(2);
    spi_cs_n = 1'b1;
    wait_clk(6);
    chk("err_partial_set", 32'(err_partial), 32'd1);
    send_byte(1'b0, 8'h5A);

    // Half pixel aborted by a command byte
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, 8'h00);
    send_byte(1'b1, 8'h34);
    chk("no_oob_yet", 32'(err_oob), 32'd0);

    // Column 400 is outside the panel: pixel dropped, err_oob set
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h90);
    send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h90);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD);
    wait_clk(4);
    chk("err_oob_set", 32'(err_oob), 32'd1);
    chk("err_partial_sticky", 32'(err_partial), 32'd1);

    for (int i = 0; i < 200 && (exp_b.size() != 0 || exp_p.size() != 0); i++) wait_clk(1);
    chk("byte_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("pix_queue_drained", 32'(exp_p.size()), 32'd0);

    // Asynchronous reset clears the sticky flags
    #2 rst_n_in = 1'b0;
    #1;
    chk("reset_err_oob", 32'(err_oob), 32'd0);
    chk("reset_err_partial", 32'(err_partial), 32'd0);
    wait_clk(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
